// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard sequencer: turns load-use, branch redirect, imem wait and
// debug halt into PC/IF-ID/ID-EX stall and flush controls, with a miss watchdog.
module fetch_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 15,
    parameter int WIDTH        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             pcsrc_e_i,
    input  logic             imem_ready_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [WIDTH-1:0] stall_cnt_o
);

    localparam int MW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_TIMEOUT);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_IWAIT  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Zero-latency hazard resolution; the unreachable encoding 11 behaves as RUN.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (rst_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (state_q == ST_HALTED) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (pcsrc_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (load_use_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (!imem_ready_i) begin
            stall_f_o = 1'b1;
            flush_d_o = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d = ST_HALTED;
                end else if (!imem_ready_i) begin
                    state_d = ST_IWAIT;
                    miss_d  = MW'(1);
                end
            end
            ST_IWAIT: begin
                if (halt_req_i) begin
                    state_d = ST_HALTED;
                    miss_d  = '0;
                end else if (pcsrc_e_i || imem_ready_i) begin
                    state_d = ST_RUN;
                    miss_d  = '0;
                end else if (miss_q == MISS_MAX) begin
                    state_d   = ST_HALTED;
                    timeout_d = 1'b1;
                    miss_d    = '0;
                end else begin
                    miss_d = miss_q + MW'(1);
                end
            end
            ST_HALTED: begin
                if (resume_i && !halt_req_i) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                miss_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f_o && (stall_cnt_q != {WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            miss_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed pins plus randomized
// traffic compared every cycle against a behavioural model of the rules.
module tb_fetch_hazard_ctrl;

    localparam int MT = 15;
    localparam int W  = 5;
    localparam int CNT_MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst, loadUse, pcsrc, ready, haltReq, resume;
    logic stallF, stallD, flushD, flushE, timeoutO;
    logic [1:0] stateO;
    logic [W-1:0] stallCnt;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 RUN, 1 IWAIT, 2 HALTED
    int mMode, mMiss, mTimeout, mCnt;
    bit eSf, eSd, eFd, eFe;

    fetch_hazard_ctrl #(.MISS_TIMEOUT(MT), .WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .load_use_i(loadUse), .pcsrc_e_i(pcsrc),
        .imem_ready_i(ready), .halt_req_i(haltReq), .resume_i(resume),
        .stall_f_o(stallF), .stall_d_o(stallD), .flush_d_o(flushD),
        .flush_e_o(flushE), .state_o(stateO), .timeout_o(timeoutO),
        .stall_cnt_o(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic computeExpected();
        {eSf, eSd, eFd, eFe} = 4'b0000;
        if (rst)                 {eSf, eSd, eFd, eFe} = 4'b0011;
        else if (mMode == 2)     {eSf, eSd, eFd, eFe} = 4'b1101;
        else if (pcsrc)          {eSf, eSd, eFd, eFe} = 4'b0011;
        else if (loadUse)        {eSf, eSd, eFd, eFe} = 4'b1101;
        else if (!ready)         {eSf, eSd, eFd, eFe} = 4'b1010;
    endtask

    task automatic applyStimulus(input bit r, input bit lu, input bit pc,
                                 input bit rdy, input bit hr, input bit rs);
        @(negedge clk);
        rst = r; loadUse = lu; pcsrc = pc; ready = rdy; haltReq = hr; resume = rs;
        #1;
        computeExpected();
    endtask

    task automatic checkOutput();
        check("stall_f", int'(stallF), int'(eSf));
        check("stall_d", int'(stallD), int'(eSd));
        check("flush_d", int'(flushD), int'(eFd));
        check("flush_e", int'(flushE), int'(eFe));
        check("state", int'(stateO), mMode);
        check("timeout", int'(timeoutO), mTimeout);
        check("stall_cnt", int'(stallCnt), mCnt);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mMode = 0; mMiss = 0; mTimeout = 0; mCnt = 0;
        end else begin
            if (eSf && mCnt < CNT_MAX) mCnt++;
            case (mMode)
                0: begin
                    if (haltReq) mMode = 2;
                    else if (!ready) begin mMode = 1; mMiss = 1; end
                end
                1: begin
                    if (haltReq) begin mMode = 2; mMiss = 0; end
                    else if (pcsrc || ready) begin mMode = 0; mMiss = 0; end
                    else if (mMiss == MT) begin mMode = 2; mTimeout = 1; mMiss = 0; end
                    else mMiss++;
                end
                default: begin
                    if (resume && !haltReq) begin mMode = 0; mTimeout = 0; end
                end
            endcase
        end
    endtask

    task automatic step(input bit r, input bit lu, input bit pc,
                        input bit rdy, input bit hr, input bit rs);
        applyStimulus(r, lu, pc, rdy, hr, rs);
        checkOutput();
        advance();
    endtask

    initial begin
        int lowRun;
        mMode = 0; mMiss = 0; mTimeout = 0; mCnt = 0;
        rst = 1'b1; loadUse = 1'b0; pcsrc = 1'b0; ready = 1'b1; haltReq = 1'b0; resume = 1'b0;

        // Reset and idle
        applyStimulus(1, 0, 0, 1, 0, 0); advance();
        step(1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_reset_state", int'(stateO), 0);
        check("lit_reset_stallf", int'(stallF), 0);
        check("lit_reset_cnt", int'(stallCnt), 0);
        check("lit_reset_timeout", int'(timeoutO), 0);
        advance();

        // Load-use, then load-use squashed by branch
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput();
        check("lit_lu_stallf", int'(stallF), 1);
        check("lit_lu_stalld", int'(stallD), 1);
        check("lit_lu_flushe", int'(flushE), 1);
        advance();
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput();
        check("lit_br_flushd", int'(flushD), 1);
        check("lit_br_stallf", int'(stallF), 0);
        check("lit_br_cnt", int'(stallCnt), 1);
        advance();

        // Three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput();
            check("lit_wait_stallf", int'(stallF), 1);
            check("lit_wait_state", int'(stateO), (i == 0) ? 0 : 1);
            advance();
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_ready_stallf", int'(stallF), 0);
        advance();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_after_wait_state", int'(stateO), 0);
        check("lit_after_wait_cnt", int'(stallCnt), 4);
        advance();

        // Watchdog expiry and resume
        for (int i = 0; i <= MT; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput();
            check("lit_wd_stallf", int'(stallF), 1);
            advance();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        check("lit_wd_state", int'(stateO), 2);
        check("lit_wd_timeout", int'(timeoutO), 1);
        advance();
        step(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_resume_state", int'(stateO), 0);
        check("lit_resume_timeout", int'(timeoutO), 0);
        advance();

        // Halt pulse, branch ignored while halted, resume blocked by halt
        step(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput();
        check("lit_halt_state", int'(stateO), 2);
        check("lit_halt_flushd", int'(flushD), 0);
        advance();
        step(0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_halt_hold", int'(stateO), 2);
        advance();

        // Saturation while halted
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_sat_cnt", int'(stallCnt), CNT_MAX);
        advance();
        step(0, 0, 0, 1, 0, 1);

        // Reset during IWAIT
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput();
        check("lit_midrst_state", int'(stateO), 0);
        check("lit_midrst_cnt", int'(stallCnt), 0);
        advance();

        // Randomized traffic with occasional long imem miss streaks
        lowRun = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, lu, pc, rdy, hr, rs;
            if (lowRun == 0 && $urandom_range(0, 11) == 0) lowRun = $urandom_range(1, 20);
            rdy = (lowRun == 0) ? ($urandom_range(0, 7) != 0) : 1'b0;
            if (lowRun > 0) lowRun--;
            r  = ($urandom_range(0, 299) == 0);
            lu = ($urandom_range(0, 5) == 0);
            pc = ($urandom_range(0, 5) == 0) && (lowRun == 0 || $urandom_range(0, 3) == 0);
            hr = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 9) == 0);
            step(r, lu, pc, rdy, hr, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
